pentary_mem_bridge: RTL and testbench

Sits directly downstream of the core's L2 unified cache external memory port. It converts the core's level-held request / mem_ready-pulse protocol into a registered valid/ready request channel plus a response channel toward the off-core memory controller. It adds a response timeout and pentary digit-legality checking on write data, and reports faults through sticky error flags.

---
 rtl/pentary_mem_pkg.sv | 23 ++
 rtl/pentary_digit_check.sv | 28 ++
 rtl/pentary_mem_bridge.sv | 167 ++++++++++++++++
 tb/tb_pentary_mem_bridge.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pentary_mem_pkg.sv
// Shared types and helpers for the pentary memory bridge and its checkers.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Digit encoding: 3 bits per pentary digit, codes 0..4 mean -2..+2, 5..7 illegal.
package pentary_mem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_e;

  localparam int                 DIGIT_W    = 3;
  localparam int                 NUM_DIGITS = 16;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX  = 3'd4;

  function automatic logic digit_legal(input logic [DIGIT_W-1:0] digit);
    return digit <= DIGIT_MAX;
  endfunction

endpackage

// File: rtl/pentary_digit_check.sv
// Flags a word containing any illegal pentary digit code (5..7).
// Latency: purely combinational, zero cycles.
// Backpressure: none; shared with the cache fill path.
//
// Ports:
//   word        in   DATA_W  word to inspect, DIGIT_W bits per digit from bit 0
//   any_illegal out  1       high when at least one digit code exceeds DIGIT_MAX
module pentary_digit_check
  import pentary_mem_pkg::*;
#(
  parameter int DATA_W = 48
) (
  input  logic [DATA_W-1:0] word,
  output logic              any_illegal
);

  localparam int N_DIG = DATA_W / DIGIT_W;

  always_comb begin
    any_illegal = 1'b0;
    for (int i = 0; i < N_DIG; i++) begin
      if (!digit_legal(word[i*DIGIT_W +: DIGIT_W])) begin
        any_illegal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pentary_mem_bridge.sv
// Converts the L2 level-held request / mem_ready-pulse port into a registered
// valid/ready request channel plus a one-strobe response channel.
// Latency: request seen in N -> bus_req_valid N+1 -> mem_ready N+3 at best.
// Backpressure: bus_req_* held stable until bus_req_ready; the core holds its
// request until the one-cycle mem_ready pulse.
//
// Ports:
//   clk, reset (async, active low)
//   mem_addr/mem_read/mem_write/mem_write_data  core request (level held)
//   mem_read_data/mem_ready                     core completion (one-cycle pulse)
//   bus_req_valid/ready/write/addr/wdata        request channel
//   bus_rsp_valid/bus_rsp_rdata                 response strobe
//   err_clear, err_timeout/err_digit/err_spurious  sticky fault flags
//   busy                                        high whenever not IDLE
module pentary_mem_bridge
  import pentary_mem_pkg::*;
#(
  parameter int ADDR_W  = 48,
  parameter int DATA_W  = 48,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] mem_write_data,
  output logic [DATA_W-1:0] mem_read_data,
  output logic              mem_ready,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_write,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic [DATA_W-1:0] bus_req_wdata,
  input  logic              bus_rsp_valid,
  input  logic [DATA_W-1:0] bus_rsp_rdata,
  input  logic              err_clear,
  output logic              err_timeout,
  output logic              err_digit,
  output logic              err_spurious,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              vld_q, vld_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdy_q, rdy_d;
  logic              to_q, to_d;
  logic              dig_q, dig_d;
  logic              spur_q, spur_d;
  logic              wdata_illegal;
  logic              set_to, set_dig, set_spur;

  pentary_digit_check #(
    .DATA_W(DATA_W)
  ) u_digit_check (
    .word       (mem_write_data),
    .any_illegal(wdata_illegal)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vld_d    = vld_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rdy_d    = 1'b0;
    set_to   = 1'b0;
    set_dig  = 1'b0;
    // Any response strobe outside WAIT_RSP (including late ones after a
    // timeout) is dropped and only recorded.
    set_spur = bus_rsp_valid && (state_q != WAIT_RSP);

    unique case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          addr_d  = mem_addr;
          wdata_d = mem_write_data;
          wr_d    = mem_write;              // write wins when both are set
          vld_d   = 1'b1;
          set_dig = mem_write && wdata_illegal;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus_req_ready) begin
          vld_d   = 1'b0;
          cnt_d   = '0;
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Response is tested first so it beats a same-cycle expiry.
        if (bus_rsp_valid) begin
          rdata_d = wr_q ? '0 : bus_rsp_rdata;
          rdy_d   = 1'b1;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d = '0;
          set_to  = 1'b1;
          rdy_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Sticky flags: a set event in the clear cycle wins.
    to_d   = (to_q   && !err_clear) || set_to;
    dig_d  = (dig_q  && !err_clear) || set_dig;
    spur_d = (spur_q && !err_clear) || set_spur;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
      to_q    <= 1'b0;
      dig_q   <= 1'b0;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      to_q    <= to_d;
      dig_q   <= dig_d;
      spur_q  <= spur_d;
    end
  end

  assign mem_read_data = rdata_q;
  assign mem_ready     = rdy_q;
  assign bus_req_valid = vld_q;
  assign bus_req_write = wr_q;
  assign bus_req_addr  = addr_q;
  assign bus_req_wdata = wdata_q;
  assign err_timeout   = to_q;
  assign err_digit     = dig_q;
  assign err_spurious  = spur_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_pentary_mem_bridge.sv
// Self-checking bench: a cycle-schedule model of each core transaction is
// compared against the bridge outputs on every cycle.
// Directed cases pin latencies and flag behaviour, then randomized traffic runs.
module tb_pentary_mem_bridge;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [47:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [47:0] mem_write_data;
  logic [47:0] mem_read_data;
  logic        mem_ready;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_write;
  logic [47:0] bus_req_addr;
  logic [47:0] bus_req_wdata;
  logic        bus_rsp_valid;
  logic [47:0] bus_rsp_rdata;
  logic        err_clear;
  logic        err_timeout;
  logic        err_digit;
  logic        err_spurious;
  logic        busy;

  always #5 clk = ~clk;

  pentary_mem_bridge #(
    .ADDR_W (48),
    .DATA_W (48),
    .TIMEOUT(TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_addr      (mem_addr),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data),
    .mem_ready     (mem_ready),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_req_write (bus_req_write),
    .bus_req_addr  (bus_req_addr),
    .bus_req_wdata (bus_req_wdata),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_rdata (bus_rsp_rdata),
    .err_clear     (err_clear),
    .err_timeout   (err_timeout),
    .err_digit     (err_digit),
    .err_spurious  (err_spurious),
    .busy          (busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Expected outputs for the current cycle, driven by the transaction schedule.
  logic        chk_on = 1'b0;
  logic        rnd_en = 1'b0;
  logic        exp_valid, exp_busy, exp_ready, exp_write;
  logic [47:0] exp_addr, exp_wdata, exp_rdata;
  logic        m_to, m_dig, m_spur;

  // Observations of the DUT used by the literal checks.
  int          ready_cnt      = 0;
  int          last_ready_cyc = 0;
  logic [47:0] last_ready_data;
  logic        last_req_write;
  logic [47:0] last_req_wdata;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic has_illegal(input logic [47:0] w);
    logic [47:0] t;
    has_illegal = 1'b0;
    for (int i = 0; i < 16; i++) begin
      t = w >> (3 * i);
      if (t[2:0] > 3'd4) has_illegal = 1'b1;
    end
  endfunction

  function automatic logic [47:0] gen_word();
    logic [47:0] w;
    int          pos;
    w = '0;
    for (int i = 0; i < 16; i++) w = w | (48'($urandom_range(0, 4)) << (3 * i));
    if ($urandom_range(0, 3) == 0) begin
      pos = $urandom_range(0, 15);
      w   = (w & ~(48'h7 << (3 * pos))) | (48'($urandom_range(5, 7)) << (3 * pos));
    end
    return w;
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("bus_req_valid", 48'(bus_req_valid), 48'(exp_valid));
      if (exp_valid) begin
        chk("bus_req_write", 48'(bus_req_write), 48'(exp_write));
        chk("bus_req_addr", bus_req_addr, exp_addr);
        chk("bus_req_wdata", bus_req_wdata, exp_wdata);
      end
      chk("busy", 48'(busy), 48'(exp_busy));
      chk("mem_ready", 48'(mem_ready), 48'(exp_ready));
      if (exp_ready) chk("mem_read_data", mem_read_data, exp_rdata);
      chk("err_timeout", 48'(err_timeout), 48'(m_to));
      chk("err_digit", 48'(err_digit), 48'(m_dig));
      chk("err_spurious", 48'(err_spurious), 48'(m_spur));
    end
    if (mem_ready) begin
      ready_cnt++;
      last_ready_cyc  = cyc;
      last_ready_data = mem_read_data;
    end
    if (bus_req_valid) begin
      last_req_write = bus_req_write;
      last_req_wdata = bus_req_wdata;
    end
  end

  // Ends the current cycle; applies the sticky-flag rules for the events of it.
  task automatic tick(input logic ev_d, input logic ev_t, input logic in_wait);
    logic ev_s;
    if (rnd_en) err_clear = ($urandom_range(0, 15) == 0);
    ev_s = bus_rsp_valid && !in_wait && reset;
    @(posedge clk);
    cyc++;
    if (reset) begin
      if (err_clear) begin
        m_to = 1'b0; m_dig = 1'b0; m_spur = 1'b0;
      end
      if (ev_t) m_to = 1'b1;
      if (ev_d) m_dig = 1'b1;
      if (ev_s) m_spur = 1'b1;
    end
    #1;
  endtask

  task automatic idle(input logic rsp);
    bus_rsp_valid = rsp;
    tick(1'b0, 1'b0, 1'b0);
    bus_rsp_valid = 1'b0;
  endtask

  // One core transaction: d cycles of backpressure, response r cycles into
  // the wait (r >= TO means no response at all).
  task automatic run_txn(input logic rd, input logic wr, input logic [47:0] addr,
                         input logic [47:0] wd, input int d, input int r,
                         input logic [47:0] rdata, input logic spur_en, output int start);
    logic to;
    int   nw;
    start          = cyc;
    mem_read       = rd;
    mem_write      = wr;
    mem_addr       = addr;
    mem_write_data = wd;
    bus_rsp_valid  = spur_en && ($urandom_range(0, 7) == 0);
    tick(wr && has_illegal(wd), 1'b0, 1'b0);
    exp_write = wr;
    exp_addr  = addr;
    exp_wdata = wd;
    exp_valid = 1'b1;
    exp_busy  = 1'b1;
    for (int j = 0; j <= d; j++) begin
      bus_req_ready = (j == d);
      bus_rsp_valid = spur_en && ($urandom_range(0, 7) == 0);
      tick(1'b0, 1'b0, 1'b0);
    end
    bus_req_ready = 1'b0;
    exp_valid     = 1'b0;
    to = (r >= TO);
    nw = to ? TO : r + 1;
    for (int k = 0; k < nw; k++) begin
      bus_rsp_valid = !to && (k == r);
      bus_rsp_rdata = (k == r) ? rdata : 48'({$urandom(), $urandom()});
      tick(1'b0, to && (k == TO - 1), 1'b1);
    end
    bus_rsp_valid = 1'b0;
    exp_ready     = 1'b1;
    exp_rdata     = (to || wr) ? 48'h0 : rdata;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    bus_rsp_valid = spur_en && ($urandom_range(0, 7) == 0);
    tick(1'b0, 1'b0, 1'b0);
    bus_rsp_valid = 1'b0;
    exp_ready     = 1'b0;
    exp_busy      = 1'b0;
  endtask

  initial begin
    int n;
    int rc0;
    reset          = 1'b0;
    mem_addr       = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_write_data = '0;
    bus_req_ready  = 1'b0;
    bus_rsp_valid  = 1'b0;
    bus_rsp_rdata  = '0;
    err_clear      = 1'b0;
    exp_valid = 1'b0; exp_busy = 1'b0; exp_ready = 1'b0; exp_write = 1'b0;
    exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
    m_to = 1'b0; m_dig = 1'b0; m_spur = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 48'(bus_req_valid), 48'h0);
    chk("rst_ready", 48'(mem_ready), 48'h0);
    chk("rst_busy", 48'(busy), 48'h0);
    chk("rst_rdata", mem_read_data, 48'h0);
    chk("rst_addr", bus_req_addr, 48'h0);
    chk("rst_flags", {45'h0, err_timeout, err_digit, err_spurious}, 48'h0);
    reset  = 1'b1;
    chk_on = 1'b1;
    idle(1'b0);
    idle(1'b0);

    // Zero-wait read: mem_ready three cycles after the request.
    rc0 = ready_cnt;
    run_txn(1'b1, 1'b0, 48'h123, 48'h0, 0, 0, 48'h42, 1'b0, n);
    chk("t1_latency", 48'(last_ready_cyc - n), 48'd3);
    chk("t1_rdata", last_ready_data, 48'h42);
    chk("t1_ready_pulses", 48'(ready_cnt - rc0), 48'd1);
    idle(1'b0);

    // Write with 5 cycles of backpressure, response one cycle into the wait.
    run_txn(1'b0, 1'b1, 48'hABC, 48'h111111111111, 5, 1, 48'hFFFF, 1'b0, n);
    chk("t2_latency", 48'(last_ready_cyc - n), 48'd9);
    chk("t2_rdata", last_ready_data, 48'h0);
    chk("t2_no_digit_err", 48'(err_digit), 48'h0);

    // Timeout, then a late response, then clear.
    run_txn(1'b1, 1'b0, 48'h55, 48'h0, 0, TO, 48'hDEAD, 1'b0, n);
    chk("t3_latency", 48'(last_ready_cyc - n), 48'd10);
    chk("t3_rdata", last_ready_data, 48'h0);
    chk("t3_timeout", 48'(err_timeout), 48'h1);
    idle(1'b1);
    chk("t3_spurious", 48'(err_spurious), 48'h1);
    err_clear = 1'b1;
    idle(1'b0);
    err_clear = 1'b0;
    chk("t3_cleared", {46'h0, err_timeout, err_spurious}, 48'h0);

    // Response on the expiry cycle completes normally.
    run_txn(1'b1, 1'b0, 48'h77, 48'h0, 0, TO - 1, 48'h1234, 1'b0, n);
    chk("t4_latency", 48'(last_ready_cyc - n), 48'd10);
    chk("t4_rdata", last_ready_data, 48'h1234);
    chk("t4_no_timeout", 48'(err_timeout), 48'h0);

    // Illegal digit 0 (code 6) with read and write both asserted.
    run_txn(1'b1, 1'b1, 48'h9, 48'h6, 0, 0, 48'hFFFF, 1'b0, n);
    chk("t5_digit", 48'(err_digit), 48'h1);
    chk("t5_write_wins", 48'(last_req_write), 48'h1);
    chk("t5_wdata", last_req_wdata, 48'h6);
    chk("t5_rdata", last_ready_data, 48'h0);
    err_clear = 1'b1;
    idle(1'b0);
    err_clear = 1'b0;

    // Async reset in WAIT_RSP.
    mem_read = 1'b1; mem_addr = 48'h31; mem_write_data = 48'h0;
    tick(1'b0, 1'b0, 1'b0);
    exp_write = 1'b0; exp_addr = 48'h31; exp_wdata = 48'h0;
    exp_valid = 1'b1; exp_busy = 1'b1;
    bus_req_ready = 1'b1; bus_rsp_valid = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; exp_valid = 1'b0;
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    chk("t6_busy_before", 48'(busy), 48'h1);
    chk("t6_spur_before", 48'(err_spurious), 48'h1);
    rc0 = ready_cnt;
    reset = 1'b0; mem_read = 1'b0;
    exp_busy = 1'b0; m_to = 1'b0; m_dig = 1'b0; m_spur = 1'b0;
    #1;
    chk("t6_async_busy", 48'(busy), 48'h0);
    chk("t6_async_flags", 48'(err_spurious), 48'h0);
    chk("t6_async_valid", 48'(bus_req_valid), 48'h0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (4) idle(1'b0);
    chk("t6_no_ready", 48'(ready_cnt - rc0), 48'h0);
    run_txn(1'b1, 1'b0, 48'h99, 48'h0, 1, 2, 48'h4321, 1'b0, n);
    chk("t6_latency", 48'(last_ready_cyc - n), 48'd6);
    chk("t6_rdata", last_ready_data, 48'h4321);

    // Randomized traffic.
    rnd_en = 1'b1;
    for (int t = 0; t < 60; t++) begin
      logic rd, wr;
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      run_txn(rd, wr, 48'({$urandom(), $urandom()}), gen_word(),
              $urandom_range(0, 3), $urandom_range(0, TO + 1),
              48'({$urandom(), $urandom()}), 1'b1, n);
      repeat ($urandom_range(0, 2)) idle($urandom_range(0, 5) == 0);
    end
    rnd_en = 1'b0;
    err_clear = 1'b0;
    idle(1'b0);
    chk_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
